// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores lfd-tagged bytes from the synchroniser
// and tracks read-side packet boundaries with a header-loaded byte counter.
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] data_out,
   output logic             pkt_active
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH:0] mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [6:0]     pkt_cnt;
   logic           wr_acc;
   logic           rd_acc;
   logic [WIDTH:0] rd_entry;

   // Extra MSB on each pointer tells a full ring from an empty one
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr_acc   = write_enb && !full;
   assign rd_acc   = read_enb && !empty;
   assign rd_entry = mem[rd_ptr[AW-1:0]];

   assign pkt_active = (pkt_cnt != 7'd0);

   // Storage is never cleared; a flush only needs the pointers to collapse
   always_ff @(posedge clk) begin
      if (resetn && !soft_reset && wr_acc)
         mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else if (soft_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= rd_entry[WIDTH-1:0];
            // Header byte bits [7:2] carry payload length; +1 covers the parity byte
            if (rd_entry[WIDTH])
               pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
            else if (pkt_cnt != 7'd0)
               pkt_cnt <= pkt_cnt - 7'd1;
         end
      end
   end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO of the 1x3 router: three instances sit directly downstream of the synchroniser, one per destination port. Each instance stores header/payload/parity bytes written under the synchroniser's one-hot `write_enb` and presents them to the external reader. It reports `full`/`empty` back to the synchroniser and honours its per-port `soft_reset` timeout flush. It also tracks packet boundaries on the read side through a header-loaded byte counter.

## Interface
- `DEPTH`, 16, number of entries; power of two.
- `WIDTH`, 8, data byte width; each entry stores WIDTH+1 bits (lfd flag + byte).
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous flush, active-high, from synchroniser.
- `write_enb`  in  1  write strobe (one bit of synchroniser `write_enb`).
- `read_enb`  in  1  read strobe from port reader.
- `lfd_state`  in  1  marks `data_in` as header byte (load-first-data).
- `data_in`  in  WIDTH  byte to store.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `data_out`  out  WIDTH  registered read data.
- `pkt_active`  out  1  a packet is partially read out.

## Operation
- Storage: DEPTH x (WIDTH+1) array; bit WIDTH = lfd flag captured with byte.
- Pointers `wr_ptr`, `rd_ptr`: log2(DEPTH)+1 bits; low bits address, MSB wrap bit. Increment modulo 2*DEPTH (15 -> 16 wraps address to 0, toggles MSB).
- `empty` = (wr_ptr == rd_ptr); `full` = addresses equal and wrap bits differ. Both combinational from registered pointers.
- Write accepted when `write_enb && !full`: store {lfd_state, data_in} at wr addr, wr_ptr+1. Write while full: dropped, no state change.
- Read accepted when `read_enb && !empty`: `data_out` <= stored byte, rd_ptr+1. Read while empty: ignored, `data_out` holds.
- Simultaneous accepted read and write (including when full or empty is not blocking): both occur same cycle; occupancy unchanged. Write while full is dropped even if a read occurs that cycle; read while empty is ignored even if a write occurs that cycle.
- Packet counter `pkt_cnt`, 7 bits:
  - Accepted read of an entry with lfd flag = 1: load `pkt_cnt` <= byte[7:2] + 1 (payload length + parity byte, range 1..64).
  - Accepted read of an entry with lfd flag = 0 while `pkt_cnt` != 0: decrement.
  - Otherwise `pkt_cnt` holds.
- `pkt_active` = (`pkt_cnt` != 0).
- `soft_reset` (sync, evaluated at clk edge, priority over read/write that cycle): wr_ptr, rd_ptr, pkt_cnt, data_out <= 0; array contents need not be cleared.
- `resetn` low (async): same clears as soft_reset, immediately, independent of clk.

## Timing
- Reset values: `full`=0, `empty`=1, `data_out`=0, `pkt_active`=0.
- Write latency: `empty` falls the cycle after the accepting edge. Data is readable on the next edge.
- Read latency: `data_out` valid 1 cycle after the edge where `read_enb && !empty`.
- `full` rises the cycle after the 16th net write; it falls the cycle after the first accepted read.
- Back-to-back reads every cycle stream one byte per cycle; no bubbles.
- Header read edge: `pkt_active` rises the following cycle. It falls in the cycle after the read that brings `pkt_cnt` to 0 (parity byte).
- `resetn` deassertion is released synchronously by the top-level; first write is accepted on the first edge with `resetn`=1.
- `soft_reset` pulse of 1 cycle: the FIFO is `empty` the next cycle, and a write on the following edge is accepted.

## Test plan
- Reset/idle: `resetn`=0 mid-stream with 5 entries -> immediately `empty`=1, `full`=0, `data_out`=0, `pkt_active`=0.
- Fill/overflow: 17 writes of 0x01..0x11 -> `full`=1 after 16th; 0x11 dropped; 16 reads return 0x01..0x10; `empty`=1 after last.
- Packet count: write header 0x0C (len 3, lfd=1), 3 payload bytes, 1 parity byte; read all -> `pkt_active` 1 for exactly 4 read cycles after header read, 0 after parity read.
- Wrap + simultaneous: pre-load 8, then 20 cycles of read+write together -> occupancy stays 8, pointers cross 15->0, data order preserved, neither flag toggles.
- Soft reset: 6 entries, `pkt_cnt`=4, pulse `soft_reset` with `write_enb`=1 same cycle -> `empty`=1, write ignored, `pkt_active`=0, `data_out`=0.
- Empty read: `read_enb`=1 for 3 cycles with `empty`=1 -> `data_out` unchanged, pointers unchanged.
